// File: rtl/limb_subtractor.sv
// Multi-cycle N-bit subtractor that processes W bits per clock using a rippled borrow.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module limb_subtractor #(
  parameter int unsigned N = 128,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned L  = N / W;
  localparam int unsigned KW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned IW = $clog2(N) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (N == 0 || W == 0 || (N % W) != 0) begin : g_bad_cfg
    $error("limb_subtractor: N must be a positive multiple of W");
  end

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [KW-1:0] k;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  d_q;
  logic          borrow;
  logic          bout_q;
  logic          in_ready_q;
  logic          out_valid_q;
`ifdef SUB_OVERFLOW_EN
  logic          ovf_q;
`endif

  logic          accept_c;
  logic          last_c;
  logic [IW-1:0] base_c;
  logic [W-1:0]  al_c;
  logic [W-1:0]  bl_c;
  logic [W:0]    diff_c;

  // Current-limb arithmetic; bit W of the extended difference is the limb borrow-out
  always_comb begin
    accept_c = in_ready_q && in_valid;
    last_c   = (k == KW'(L - 1));
    base_c   = IW'(k) * IW'(W);
    al_c     = a_q[base_c +: W];
    bl_c     = b_q[base_c +: W];
    diff_c   = {1'b0, al_c} - {1'b0, bl_c} - (W + 1)'(borrow);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = BUSY;
      BUSY:    if (last_c) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nx == IDLE);
      out_valid_q <= (state_nx == DONE);
    end
  end

  // Operand capture and one limb per BUSY cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      k      <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            k      <= '0;
          end
        end
        BUSY: begin
          d_q[base_c +: W] <= diff_c[W-1:0];
          borrow           <= diff_c[W];
          if (last_c) begin
            k      <= '0;
            bout_q <= diff_c[W];
`ifdef SUB_OVERFLOW_EN
            // Signs of operands differ and the result sign departs from the minuend
            ovf_q  <= (a_q[N-1] ^ b_q[N-1]) & (diff_c[W-1] ^ a_q[N-1]);
`endif
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule
